// File: rtl/prog_loader.sv
// prog_loader: writer side of the uP program-memory interface.
// Takes a host byte stream of the form LEN_HI, LEN_LO, DATA[len], CHECKSUM and writes the data
// bytes into program memory from BASE_ADDR upwards. It holds the uP in reset while loading and
// releases it only when the 8-bit additive checksum of the data bytes matches.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      asynchronous, active-high reset
//   i_start      load request pulse, honoured only when idle, done or in error
//   i_rx_valid   host byte valid
//   i_rx_data    host byte
//   o_rx_ready   loader accepts a byte this cycle (equal to o_busy)
//   o_mem_we     program-memory write strobe, one cycle per data byte
//   o_mem_addr   program-memory write address
//   o_mem_wdata  program-memory write data
//   o_cpu_hold   uP reset: high while loading and after an error
//   o_busy       high while a load is in progress
//   o_done       high after a verified load
//   o_err_code   00 none, 01 bad header, 10 checksum mismatch, 11 timeout
module prog_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_rx_valid,
  input  logic [DATA_W-1:0] i_rx_data,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_err_code
);

  // Upper length bits carried in the low nibble of the LEN_HI byte.
  localparam int unsigned HiW  = ADDR_W - DATA_W;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLenHi, StLenLo, StData, StCheck, StDone, StErr
  } state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_sum;
  logic [TmoW-1:0]     r_tmo;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_hold;
  logic [1:0]          r_err;

  logic w_busy;
  logic w_accept;
  logic w_tmo_hit;

  assign w_busy    = (r_state == StLenHi) || (r_state == StLenLo) ||
                     (r_state == StData)  || (r_state == StCheck);
  assign w_accept  = i_rx_valid && w_busy;
  // Counter value on the last idle cycle allowed; one more idle edge expires the load.
  assign w_tmo_hit = (r_tmo == TmoW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_tmo   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_hold  <= 1'b0;
      r_err   <= 2'b00;
    end else begin
      r_we <= 1'b0;

      // Idle-cycle watchdog; an accept on the expiry edge takes priority below.
      if (w_busy && !w_accept) begin
        if (w_tmo_hit) begin
          r_state <= StErr;
          r_err   <= 2'b11;
        end else begin
          r_tmo <= r_tmo + TmoW'(1);
        end
      end

      case (r_state)
        StIdle, StDone, StErr: begin
          if (i_start) begin
            r_state <= StLenHi;
            r_hold  <= 1'b1;
            r_err   <= 2'b00;
            r_len   <= '0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_tmo   <= '0;
          end
        end
        StLenHi: begin
          if (w_accept) begin
            r_tmo <= '0;
            if (i_rx_data[DATA_W-1:HiW] != '0) begin
              r_state <= StErr;
              r_err   <= 2'b01;
            end else begin
              r_len[ADDR_W-1:DATA_W] <= i_rx_data[HiW-1:0];
              r_state                <= StLenLo;
            end
          end
        end
        StLenLo: begin
          if (w_accept) begin
            r_tmo              <= '0;
            r_len[DATA_W-1:0]  <= i_rx_data;
            if ({r_len[ADDR_W-1:DATA_W], i_rx_data} == '0) r_state <= StCheck;
            else                                            r_state <= StData;
          end
        end
        StData: begin
          if (w_accept) begin
            r_tmo   <= '0;
            r_we    <= 1'b1;
            r_addr  <= ADDR_W'(BASE_ADDR) + r_idx;  // wraps at 2^ADDR_W by truncation
            r_wdata <= i_rx_data;
            r_idx   <= r_idx + ADDR_W'(1);
            r_sum   <= r_sum + i_rx_data;
            if (r_idx + ADDR_W'(1) == r_len) r_state <= StCheck;
          end
        end
        StCheck: begin
          if (w_accept) begin
            r_tmo <= '0;
            if (i_rx_data == r_sum) begin
              r_state <= StDone;
              r_hold  <= 1'b0;
            end else begin
              r_state <= StErr;
              r_err   <= 2'b10;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rx_ready  = w_busy;
  assign o_busy      = w_busy;
  assign o_done      = (r_state == StDone);
  assign o_mem_we    = r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_cpu_hold  = r_hold;
  assign o_err_code  = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader. Two instances share the stimulus: u_dut_a uses the
// default parameters, u_dut_b uses BASE_ADDR = 0xFFE and TIMEOUT = 4 for the wrap and
// timeout scenarios. Memory writes of each instance are logged on the falling edge.
module tb_prog_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rx_valid;
  logic [7:0] rx_data;

  logic        a_ready, a_we, a_hold, a_busy, a_done;
  logic [11:0] a_addr;
  logic [7:0]  a_wdata;
  logic [1:0]  a_err;

  logic        b_ready, b_we, b_hold, b_busy, b_done;
  logic [11:0] b_addr;
  logic [7:0]  b_wdata;
  logic [1:0]  b_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [11:0] wa_addr[$];
  logic [7:0]  wa_data[$];
  int          wa_cyc[$];
  logic [11:0] wb_addr[$];
  logic [7:0]  wb_data[$];

  prog_loader u_dut_a (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_rx_ready  (a_ready),
    .o_mem_we    (a_we),
    .o_mem_addr  (a_addr),
    .o_mem_wdata (a_wdata),
    .o_cpu_hold  (a_hold),
    .o_busy      (a_busy),
    .o_done      (a_done),
    .o_err_code  (a_err)
  );

  prog_loader #(
    .BASE_ADDR (12'hFFE),
    .TIMEOUT   (4)
  ) u_dut_b (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_rx_valid  (rx_valid),
    .i_rx_data   (rx_data),
    .o_rx_ready  (b_ready),
    .o_mem_we    (b_we),
    .o_mem_addr  (b_addr),
    .o_mem_wdata (b_wdata),
    .o_cpu_hold  (b_hold),
    .o_busy      (b_busy),
    .o_done      (b_done),
    .o_err_code  (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_we) begin
      wa_addr.push_back(a_addr);
      wa_data.push_back(a_wdata);
      wa_cyc.push_back(cyc);
    end
    if (b_we) begin
      wb_addr.push_back(b_addr);
      wb_data.push_back(b_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; presents one byte for exactly one rising edge.
  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_logs();
    wa_addr.delete();
    wa_data.delete();
    wa_cyc.delete();
    wb_addr.delete();
    wb_data.delete();
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check("rst outputs", {a_ready, a_we, a_hold, a_busy, a_done, a_err, a_addr, a_wdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle hold", a_hold, 0);

    // Reset in the middle of the data phase.
    pulse_start();
    check("hold after start", a_hold, 1);
    check("ready after start", a_ready, 1);
    put(8'h00); put(8'h05); put(8'h11); put(8'h22);
    #1;
    check("midrst writes before", wa_addr.size(), 2);
    reset = 1'b1;
    #1;
    check("midrst outputs", {a_ready, a_we, a_hold, a_busy, a_done, a_err, a_addr, a_wdata}, 0);
    @(negedge clk);
    put(8'h33);
    reset = 1'b0;
    put(8'h44); put(8'h55);
    idle(2);
    #1;
    check("midrst no writes", wa_addr.size(), 2);
    check("midrst idle", a_busy, 0);
    clear_logs();
    pulse_start();
    put(8'h00); put(8'h01); put(8'h7E); put(8'h7E);
    idle(1);
    #1;
    check("restart done", a_done, 1);
    check("restart nwr", wa_addr.size(), 1);
    check("restart wr", {wa_addr[0], wa_data[0]}, {12'h000, 8'h7E});

    // Good three-byte load.
    clear_logs();
    pulse_start();
    put(8'h00); put(8'h03); put(8'hA1); put(8'hB2); put(8'h0C); put(8'h5F);
    idle(1);
    #1;
    check("good nwr", wa_addr.size(), 3);
    check("good wr0", {wa_addr[0], wa_data[0]}, {12'h000, 8'hA1});
    check("good wr1", {wa_addr[1], wa_data[1]}, {12'h001, 8'hB2});
    check("good wr2", {wa_addr[2], wa_data[2]}, {12'h002, 8'h0C});
    check("good b2b 01", wa_cyc[1] - wa_cyc[0], 1);
    check("good b2b 12", wa_cyc[2] - wa_cyc[1], 1);
    check("good done/hold/err", {a_done, a_hold, a_busy, a_err}, {1'b1, 1'b0, 1'b0, 2'b00});

    // Same stream, wrong checksum.
    clear_logs();
    pulse_start();
    check("restart from done hold", a_hold, 1);
    put(8'h00); put(8'h03); put(8'hA1); put(8'hB2); put(8'h0C); put(8'h60);
    idle(1);
    #1;
    check("badsum nwr", wa_addr.size(), 3);
    check("badsum state", {a_done, a_hold, a_busy, a_err}, {1'b0, 1'b1, 1'b0, 2'b10});

    // Bad header, then zero-length load.
    clear_logs();
    pulse_start();
    check("start clears err", a_err, 0);
    put(8'h10);
    idle(1);
    #1;
    check("badhdr state", {a_done, a_hold, a_busy, a_err}, {1'b0, 1'b1, 1'b0, 2'b01});
    check("badhdr nwr", wa_addr.size(), 0);
    clear_logs();
    pulse_start();
    put(8'h00); put(8'h00); put(8'h00);
    idle(1);
    #1;
    check("zerolen state", {a_done, a_hold, a_busy, a_err}, {1'b1, 1'b0, 1'b0, 2'b00});
    check("zerolen nwr", wa_addr.size(), 0);

    // Address wrap on the 0xFFE-based instance.
    clear_logs();
    pulse_start();
    put(8'h00); put(8'h03); put(8'h01); put(8'h02); put(8'h03); put(8'h06);
    idle(1);
    #1;
    check("wrap nwr", wb_addr.size(), 3);
    check("wrap wr0", {wb_addr[0], wb_data[0]}, {12'hFFE, 8'h01});
    check("wrap wr1", {wb_addr[1], wb_data[1]}, {12'hFFF, 8'h02});
    check("wrap wr2", {wb_addr[2], wb_data[2]}, {12'h000, 8'h03});
    check("wrap done", {b_done, b_hold, b_err}, {1'b1, 1'b0, 2'b00});

    // Timeout: one data byte then silence; expires on the fourth idle edge.
    clear_logs();
    pulse_start();
    put(8'h00); put(8'h02); put(8'h05);
    idle(3);
    #1;
    check("tmo not yet busy", b_busy, 1);
    check("tmo not yet err", b_err, 0);
    idle(1);
    #1;
    check("tmo state", {b_busy, b_hold, b_done, b_err}, {1'b0, 1'b1, 1'b0, 2'b11});
    check("tmo nwr", wb_addr.size(), 1);

    // Three idle cycles between bytes: accept lands on the expiry edge and wins.
    clear_logs();
    pulse_start();
    put(8'h00); idle(3);
    put(8'h02); idle(3);
    put(8'h11); idle(3);
    put(8'h22); idle(3);
    put(8'h33);
    idle(1);
    #1;
    check("gap state", {b_done, b_hold, b_busy, b_err}, {1'b1, 1'b0, 1'b0, 2'b00});
    check("gap nwr", wb_addr.size(), 2);
    check("gap wr0", {wb_addr[0], wb_data[0]}, {12'hFFE, 8'h11});
    check("gap wr1", {wb_addr[1], wb_data[1]}, {12'hFFF, 8'h22});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
